// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file.
//   REG_IDX_W      : width of a register index
//   ERR_SRC_*      : encoding of the latched error source
//   scrub_state_e  : background scrubber states
//   err_t          : one error record (used both as candidate and as latch)
package regfile_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] ERR_SRC_P1    = 2'b01;
  localparam logic [1:0] ERR_SRC_P2    = 2'b10;
  localparam logic [1:0] ERR_SRC_SCRUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } scrub_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic [1:0]           src;
  } err_t;

  // Successor of a scan index: walks 1..nreg-1 and wraps past x0.
  function automatic logic [REG_IDX_W-1:0] scrub_next(input logic [REG_IDX_W-1:0] idx,
                                                      input int nreg);
    if (idx >= REG_IDX_W'(nreg - 1)) return REG_IDX_W'(1);
    else                             return idx + REG_IDX_W'(1);
  endfunction

endpackage

// File: rtl/regfile_scrubber.sv
// Background parity scrubber.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en/wr_idx : writeback port; an entry being written this cycle is skipped
//   mismatch     : parity mismatch of the entry at scrub_idx (computed by the owner of storage)
//   err_clr      : releases the scrubber from S_HOLD
//   scrub_idx    : entry checked this cycle
//   scrub_err    : error candidate raised on the cycle a mismatch is detected
// EN=0 parks the scrubber in S_IDLE with scrub_idx at 0 and no candidate.
module regfile_scrubber
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter bit EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic                 mismatch,
  input  logic                 err_clr,
  output logic [REG_IDX_W-1:0] scrub_idx,
  output logic                 scrub_err
);

  scrub_state_e         state;
  logic [REG_IDX_W-1:0] idx;
  logic                 skip;

  // An entry being rewritten this cycle is about to become consistent, so
  // reporting it would only produce a stale error.
  assign skip      = wr_en && (wr_idx == idx);
  assign scrub_err = (state == S_RUN) && !skip && mismatch;
  assign scrub_idx = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EN ? S_RUN : S_IDLE;
      idx   <= EN ? REG_IDX_W'(1) : '0;
    end else begin
      unique case (state)
        S_RUN: begin
          // Freeze on a hit so the handler can see which entry tripped.
          if (scrub_err) state <= S_HOLD;
          else           idx   <= scrub_next(idx, NREG);
        end
        S_HOLD: begin
          if (err_clr) begin
            state <= S_RUN;
            idx   <= scrub_next(idx, NREG);
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_fault.sv
// Integer register file with per-entry even parity, read-port and background
// error detection, first-error latch and single-bit fault injection.
//   clk, rst              : clock, synchronous active-high reset
//   RegWriteW/RdW/ResultW : writeback write port (x0 ignored)
//   Rs1D/Rs2D -> RD1D/RD2D: combinational read ports with write-through bypass
//   perr1D/perr2D         : parity error on the corresponding read
//   inj_en/inj_idx/inj_bit: flip one stored data bit (parity left untouched)
//   err_clr               : clear / re-arm the error latch
//   err_valid/idx/src     : first latched error
//   scrub_idx             : entry the scrubber checks this cycle
module regfile_fault
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int XLEN     = 32,
  parameter bit SCRUB_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteW,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic [XLEN-1:0]      ResultW,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  output logic [XLEN-1:0]      RD1D,
  output logic [XLEN-1:0]      RD2D,
  output logic                 perr1D,
  output logic                 perr2D,
  input  logic                 inj_en,
  input  logic [REG_IDX_W-1:0] inj_idx,
  input  logic [4:0]           inj_bit,
  input  logic                 err_clr,
  output logic                 err_valid,
  output logic [REG_IDX_W-1:0] err_idx,
  output logic [1:0]           err_src,
  output logic [REG_IDX_W-1:0] scrub_idx
);

  localparam int NRP = 2;

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] par;

  logic                           wr_ok;
  logic                           inj_ok;
  logic [NRP-1:0][REG_IDX_W-1:0]  rs_idx;
  logic [NRP-1:0][XLEN-1:0]       rd_data;
  logic [NRP-1:0]                 perr;
  logic                           scrub_mis;
  logic                           scrub_err;
  err_t                           cand;
  err_t                           err_q;

  assign wr_ok  = RegWriteW && (RdW != '0);
  // A write to the same entry on the same edge supersedes the injection.
  assign inj_ok = inj_en && (inj_idx != '0) && !(wr_ok && (RdW == inj_idx));

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      par <= '0;
    end else begin
      if (inj_ok) mem[inj_idx][inj_bit] <= ~mem[inj_idx][inj_bit];
      if (wr_ok) begin
        mem[RdW] <= ResultW;
        par[RdW] <= ^ResultW;
      end
    end
  end

  // ---------------- read ports ----------------
  assign rs_idx = {Rs2D, Rs1D};

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic byp;
    // Bypassed reads return the incoming value, whose parity is fresh, so
    // no error is reported for them.
    assign byp        = RegWriteW && (RdW == rs_idx[p]);
    assign rd_data[p] = (rs_idx[p] == '0) ? '0 :
                        byp               ? ResultW : mem[rs_idx[p]];
    assign perr[p]    = (rs_idx[p] != '0) && !byp &&
                        ((^mem[rs_idx[p]]) != par[rs_idx[p]]);
  end

  assign RD1D   = rd_data[0];
  assign RD2D   = rd_data[1];
  assign perr1D = perr[0];
  assign perr2D = perr[1];

  // ---------------- scrubber ----------------
  assign scrub_mis = (^mem[scrub_idx]) != par[scrub_idx];

  regfile_scrubber #(
    .NREG (NREG),
    .EN   (SCRUB_EN)
  ) u_scrub (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (RegWriteW),
    .wr_idx    (RdW),
    .mismatch  (scrub_mis),
    .err_clr   (err_clr),
    .scrub_idx (scrub_idx),
    .scrub_err (scrub_err)
  );

  // ---------------- error latch ----------------
  always_comb begin
    cand = '0;
    if (perr[0])        cand = '{valid: 1'b1, idx: rs_idx[0], src: ERR_SRC_P1};
    else if (perr[1])   cand = '{valid: 1'b1, idx: rs_idx[1], src: ERR_SRC_P2};
    else if (scrub_err) cand = '{valid: 1'b1, idx: scrub_idx, src: ERR_SRC_SCRUB};
  end

  // First-error capture: the latch is open only while empty or being
  // cleared, so err_clr with a fresh candidate re-arms straight onto it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (!err_q.valid || err_clr) begin
      if (cand.valid) err_q       <= cand;
      else            err_q.valid <= 1'b0;
    end
  end

  assign err_valid = err_q.valid;
  assign err_idx   = err_q.idx;
  assign err_src   = err_q.src;

endmodule

// File: tb/tb_regfile_fault.sv
module tb_regfile_fault;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  Rs1D, Rs2D;
  logic [31:0] RD1D, RD2D;
  logic        perr1D, perr2D;
  logic        inj_en;
  logic [4:0]  inj_idx, inj_bit;
  logic        err_clr;
  logic        err_valid;
  logic [4:0]  err_idx;
  logic [1:0]  err_src;
  logic [4:0]  scrub_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_fault #(.NREG(32), .XLEN(32), .SCRUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
    .perr1D(perr1D), .perr2D(perr2D),
    .inj_en(inj_en), .inj_idx(inj_idx), .inj_bit(inj_bit),
    .err_clr(err_clr), .err_valid(err_valid), .err_idx(err_idx), .err_src(err_src),
    .scrub_idx(scrub_idx)
  );

  // ---- reference model: contents plus a "corrupted" flag per register ----
  logic [31:0] mval [32];
  bit          bad  [32];
  bit          m_ev;
  logic [4:0]  m_eidx;
  logic [1:0]  m_esrc;
  logic [4:0]  m_sidx;
  bit          m_hold;

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWriteW && RdW == idx) return ResultW;
    return mval[idx];
  endfunction

  function automatic bit exp_perr(input logic [4:0] idx);
    return (idx != 0) && !(RegWriteW && RdW == idx) && bad[idx];
  endfunction

  task automatic idle();
    rst = 0; RegWriteW = 0; RdW = 0; ResultW = 0; Rs1D = 0; Rs2D = 0;
    inj_en = 0; inj_idx = 0; inj_bit = 0; err_clr = 0;
  endtask

  // Advance one clock edge and step the model with the inputs currently applied.
  task automatic tick();
    bit c1, c2, cs;
    logic [4:0] nxt;
    c1  = exp_perr(Rs1D);
    c2  = exp_perr(Rs2D);
    cs  = !m_hold && bad[m_sidx] && !(RegWriteW && RdW == m_sidx);
    nxt = (m_sidx == 5'd31) ? 5'd1 : m_sidx + 5'd1;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mval[i] = 0; bad[i] = 0; end
      m_ev = 0; m_eidx = 0; m_esrc = 0; m_sidx = 1; m_hold = 0;
    end else begin
      if (!m_ev || err_clr) begin
        if (c1)      begin m_ev = 1; m_eidx = Rs1D;   m_esrc = 2'b01; end
        else if (c2) begin m_ev = 1; m_eidx = Rs2D;   m_esrc = 2'b10; end
        else if (cs) begin m_ev = 1; m_eidx = m_sidx; m_esrc = 2'b11; end
        else m_ev = 0;
      end
      if (!m_hold) begin
        if (cs) m_hold = 1; else m_sidx = nxt;
      end else if (err_clr) begin
        m_hold = 0; m_sidx = nxt;
      end
      if (inj_en && inj_idx != 0 && !(RegWriteW && RdW == inj_idx)) begin
        mval[inj_idx] = mval[inj_idx] ^ (32'h1 << inj_bit);
        bad[inj_idx]  = !bad[inj_idx];
      end
      if (RegWriteW && RdW != 0) begin
        mval[RdW] = ResultW; bad[RdW] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    Rs1D = 5'd13; Rs2D = 5'd0; #1;
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %0b want 0", err_valid); end
    checks++; if (err_idx !== 5'd0) begin errors++; $display("FAIL reset_err_idx got %0d want 0", err_idx); end
    checks++; if (err_src !== 2'b00) begin errors++; $display("FAIL reset_err_src got %0b want 00", err_src); end
    checks++; if (scrub_idx !== 5'd1) begin errors++; $display("FAIL reset_scrub_idx got %0d want 1", scrub_idx); end
    checks++; if (RD1D !== 32'h0 || perr1D !== 1'b0) begin errors++; $display("FAIL reset_read got %h/%0b want 0/0", RD1D, perr1D); end
    idle();
  endtask

  task automatic test_write_read();
    do_reset();
    RegWriteW = 1; RdW = 5; ResultW = 32'h0000_00FF; tick(); idle();
    Rs1D = 5; Rs2D = 0; #1;
    checks++; if (RD1D !== 32'h0000_00FF) begin errors++; $display("FAIL wr_rd1 got %h want 000000ff", RD1D); end
    checks++; if (perr1D !== 1'b0) begin errors++; $display("FAIL wr_perr1 got %0b want 0", perr1D); end
    checks++; if (RD2D !== 32'h0) begin errors++; $display("FAIL wr_rd2_x0 got %h want 0", RD2D); end
    tick(); idle();
  endtask

  task automatic test_bypass();
    RegWriteW = 1; RdW = 7; ResultW = 32'hDEAD_BEEF; Rs1D = 7; #1;
    checks++; if (RD1D !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1 got %h want deadbeef", RD1D); end
    checks++; if (perr1D !== 1'b0) begin errors++; $display("FAIL bypass_perr1 got %0b want 0", perr1D); end
    tick(); idle();
  endtask

  task automatic test_inject_read();
    do_reset();
    RegWriteW = 1; RdW = 3; ResultW = 32'h1; tick(); idle();
    inj_en = 1; inj_idx = 3; inj_bit = 4; tick(); idle();
    Rs2D = 3; #1;
    checks++; if (RD2D !== 32'h11) begin errors++; $display("FAIL inj_rd2 got %h want 00000011", RD2D); end
    checks++; if (perr2D !== 1'b1) begin errors++; $display("FAIL inj_perr2 got %0b want 1", perr2D); end
    tick(); idle();
    checks++; if (err_valid !== 1'b1 || err_idx !== 5'd3 || err_src !== 2'b10) begin
      errors++; $display("FAIL inj_latch got v=%0b idx=%0d src=%b want v=1 idx=3 src=10", err_valid, err_idx, err_src); end
  endtask

  task automatic test_scrub();
    int n;
    do_reset();
    inj_en = 1; inj_idx = 20; inj_bit = 0; tick(); idle();
    n = 0;
    while (!err_valid && n < 40) begin tick(); n++; end
    checks++; if (n >= 40) begin errors++; $display("FAIL scrub_timeout got no error after %0d cycles want <=31", n); end
    checks++; if (err_idx !== 5'd20 || err_src !== 2'b11) begin
      errors++; $display("FAIL scrub_latch got idx=%0d src=%b want idx=20 src=11", err_idx, err_src); end
    tick();
    checks++; if (scrub_idx !== 5'd20) begin errors++; $display("FAIL scrub_frozen got %0d want 20", scrub_idx); end
    err_clr = 1; tick(); idle();
    checks++; if (scrub_idx !== 5'd21) begin errors++; $display("FAIL scrub_resume got %0d want 21", scrub_idx); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL scrub_clr got %0b want 0", err_valid); end
  endtask

  task automatic test_inject_write_collision();
    do_reset();
    RegWriteW = 1; RdW = 9; ResultW = 32'h1234_5670; inj_en = 1; inj_idx = 9; inj_bit = 4; tick(); idle();
    Rs1D = 9; #1;
    checks++; if (RD1D !== 32'h1234_5670 || perr1D !== 1'b0) begin
      errors++; $display("FAIL collide_rd got %h/%0b want 12345670/0", RD1D, perr1D); end
    for (int i = 0; i < 35; i++) tick();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL collide_no_err got %0b want 0", err_valid); end
    idle();
  endtask

  task automatic test_x0_and_hold_reset();
    int n;
    do_reset();
    RegWriteW = 1; RdW = 0; ResultW = 32'hFFFF_FFFF; inj_en = 1; inj_idx = 0; inj_bit = 7; tick(); idle();
    Rs1D = 0; #1;
    checks++; if (RD1D !== 32'h0 || perr1D !== 1'b0) begin errors++; $display("FAIL x0_read got %h/%0b want 0/0", RD1D, perr1D); end
    inj_en = 1; inj_idx = 12; inj_bit = 31; tick(); idle();
    n = 0;
    while (!err_valid && n < 40) begin tick(); n++; end
    checks++; if (n >= 40 || err_idx !== 5'd12) begin errors++; $display("FAIL hold_entry got idx=%0d after %0d cycles want 12", err_idx, n); end
    tick(); tick();
    rst = 1; tick(); rst = 0;
    checks++; if (err_valid !== 1'b0 || scrub_idx !== 5'd1) begin
      errors++; $display("FAIL hold_reset got v=%0b sidx=%0d want 0/1", err_valid, scrub_idx); end
    tick();
    checks++; if (scrub_idx !== 5'd2) begin errors++; $display("FAIL hold_reset_run got %0d want 2", scrub_idx); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      RegWriteW = ($urandom_range(0, 2) == 0);
      RdW       = 5'($urandom);
      ResultW   = $urandom;
      Rs1D      = 5'($urandom);
      Rs2D      = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom);
      inj_en    = ($urandom_range(0, 5) == 0);
      inj_idx   = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom);
      inj_bit   = 5'($urandom);
      err_clr   = ($urandom_range(0, 7) == 0);
      #1;
      checks++; if (RD1D !== exp_rd(Rs1D) || perr1D !== exp_perr(Rs1D)) begin
        errors++; $display("FAIL rnd_p1 cyc=%0d idx=%0d got %h/%0b want %h/%0b", c, Rs1D, RD1D, perr1D, exp_rd(Rs1D), exp_perr(Rs1D)); end
      checks++; if (RD2D !== exp_rd(Rs2D) || perr2D !== exp_perr(Rs2D)) begin
        errors++; $display("FAIL rnd_p2 cyc=%0d idx=%0d got %h/%0b want %h/%0b", c, Rs2D, RD2D, perr2D, exp_rd(Rs2D), exp_perr(Rs2D)); end
      tick();
      checks++; if (err_valid !== m_ev || (m_ev && (err_idx !== m_eidx || err_src !== m_esrc))) begin
        errors++; $display("FAIL rnd_err cyc=%0d got v=%0b idx=%0d src=%b want v=%0b idx=%0d src=%b",
                           c, err_valid, err_idx, err_src, m_ev, m_eidx, m_esrc); end
      checks++; if (scrub_idx !== m_sidx) begin
        errors++; $display("FAIL rnd_scrub cyc=%0d got %0d want %0d", c, scrub_idx, m_sidx); end
    end
    idle();
  endtask

  initial begin
    idle();
    m_sidx = 1; m_hold = 0; m_ev = 0; m_eidx = 0; m_esrc = 0;
    for (int i = 0; i < 32; i++) begin mval[i] = 0; bad[i] = 0; end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_inject_read();
    test_scrub();
    test_inject_write_collision();
    test_x0_and_hold_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
